// File: rtl/sorter_pkg.sv
// Shared types and helpers for bubble_sorter_n: FSM state encoding,
// counter sizing and the element compare used by every compare-exchange cell.
package sorter_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Widest element the shared compare handles; narrower elements are zero-extended.
    localparam int MAX_W = 64;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic needs_swap(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             descend
    );
        return descend ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/sorter_cmp_swap.sv
// One compare-exchange cell: when enabled and the pair is out of order,
// the two elements are exchanged; otherwise they pass straight through.
module sorter_cmp_swap
    import sorter_pkg::*;
#(
    parameter int W       = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic         en,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic         swapped
);

    always_comb begin
        swapped = en && needs_swap(MAX_W'(a_in), MAX_W'(b_in), DESCEND);
        a_out   = swapped ? b_in : a_in;
        b_out   = swapped ? a_in : b_in;
    end

endmodule

// File: rtl/bubble_sorter_n.sv
// Batch sorter: load N elements, run odd-even transposition phases, stream out.
// Optional macro SORTER_EARLY_EXIT_EN ends SORT once an even/odd phase pair makes no swaps.
module bubble_sorter_n
    import sorter_pkg::*;
#(
    parameter int W       = 8,
    parameter int N       = 3,
    parameter bit DESCEND = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int            CW   = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [W-1:0]  elem_q [N];
    logic [W-1:0]  elem_d [N];
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
`ifdef SORTER_EARLY_EXIT_EN
    logic          prev_swap_q, prev_swap_d;
`endif

    logic [N-2:0]  cell_en;
    logic [N-2:0]  cell_swap;
    logic [W-1:0]  cell_a [N-1];
    logic [W-1:0]  cell_b [N-1];
    logic [W-1:0]  sorted [N];
    logic          any_swap;
    logic          sort_done;

    // Cell k owns pair (k, k+1); its parity selects the phase it is active in.
    for (genvar k = 0; k < N - 1; k++) begin : g_cell
        assign cell_en[k] = (state_q == SORT) && (1'(k) == phase_q[0]);

        sorter_cmp_swap #(
            .W       (W),
            .DESCEND (DESCEND)
        ) u_cell (
            .en      (cell_en[k]),
            .a_in    (elem_q[k]),
            .b_in    (elem_q[k+1]),
            .a_out   (cell_a[k]),
            .b_out   (cell_b[k]),
            .swapped (cell_swap[k])
        );
    end

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        sorted = elem_q;
        for (int k = 0; k < N - 1; k++) begin
            if (cell_en[k]) begin
                sorted[k]   = cell_a[k];
                sorted[k+1] = cell_b[k];
            end
        end
        any_swap = |cell_swap;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        elem_d    = elem_q;
        sort_done = 1'b0;
`ifdef SORTER_EARLY_EXIT_EN
        prev_swap_d = prev_swap_q;
`endif

        case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    elem_d[cnt_q] = in_data;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        phase_d = '0;
                        state_d = SORT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            SORT: begin
                elem_d    = sorted;
                phase_d   = phase_q + CW'(1);
                sort_done = (phase_q == LAST);
`ifdef SORTER_EARLY_EXIT_EN
                // An odd phase always follows an even one within the same batch.
                prev_swap_d = any_swap;
                if (phase_q[0] && !any_swap && !prev_swap_q) begin
                    sort_done = 1'b1;
                end
`endif
                if (sort_done) begin
                    phase_d = '0;
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = LOAD;
                cnt_d   = '0;
                phase_d = '0;
            end
        endcase

        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != LOAD);
    end

    // NOTE: sequential state uses non-blocking assignments only; the buffer is reset
    // because a reset must discard any partially loaded or sorted batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            phase_q     <= '0;
            for (int i = 0; i < N; i++) begin
                elem_q[i] <= '0;
            end
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SORTER_EARLY_EXIT_EN
            prev_swap_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            elem_q      <= elem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SORTER_EARLY_EXIT_EN
            prev_swap_q <= prev_swap_d;
`endif
        end
    end

    // The drain index is stable while stalled, so out_data/out_last hold too.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_valid_q ? elem_q[cnt_q] : '0;
    assign out_last  = out_valid_q && (cnt_q == LAST);

endmodule

// File: tb/tb_bubble_sorter_n.sv
// Directed bench for bubble_sorter_n: an ascending N=3 instance and a descending N=5 instance.
module tb_bubble_sorter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, out_last3, busy3;
    logic [7:0] in_data3, out_data3;
    logic       in_valid5, in_ready5, out_valid5, out_ready5, out_last5, busy5;
    logic [7:0] in_data5, out_data5;

    bubble_sorter_n #(.W(8), .N(3), .DESCEND(1'b0)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .out_last  (out_last3),
        .busy      (busy3)
    );

    bubble_sorter_n #(.W(8), .N(5), .DESCEND(1'b1)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .in_data   (in_data5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_data  (out_data5),
        .out_last  (out_last5),
        .busy      (busy5)
    );

    // Pushes three elements back to back; acc is the cycle of the last accept.
    task automatic load3(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                         input string name, output int acc);
        logic [7:0] v [3];
        v[0] = v0; v[1] = v1; v[2] = v2;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid3 = 1'b1;
            in_data3  = v[i];
            checks++;
            if (in_ready3 !== 1'b1) begin
                errors++;
                $display("FAIL %s_in_ready[%0d]: got %b expected 1", name, i, in_ready3);
            end
            acc = cyc;
        end
        @(negedge clk);
        in_valid3 = 1'b0;
        in_data3  = 8'h00;
    endtask

    task automatic wait_valid3(input int acc, input int exp_lat, input string name);
        int k = 0;
        while (out_valid3 !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (out_valid3 !== 1'b1 || (cyc - acc) != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got valid=%b after %0d cycles expected 1 after %0d",
                     name, out_valid3, cyc - acc, exp_lat);
        end
    endtask

    // Expects out_ready3=1 and to be entered at a negedge where out_valid3 is already high.
    task automatic collect3(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input string name);
        logic [7:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid3 !== 1'b1 || out_data3 !== e[i] || out_last3 !== (i == 2)) begin
                errors++;
                $display("FAIL %s_out[%0d]: got valid=%b data=%0d last=%b expected 1 %0d %b",
                         name, i, out_valid3, out_data3, out_last3, e[i], (i == 2));
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL %s_return: got ready=%b valid=%b busy=%b expected 1 0 0",
                     name, in_ready3, out_valid3, busy3);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || out_data3 !== 8'd0 ||
            out_last3 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut3: got ready=%b valid=%b data=%0d last=%b busy=%b expected 1 0 0 0 0",
                     in_ready3, out_valid3, out_data3, out_last3, busy3);
        end
        checks++;
        if (in_ready5 !== 1'b1 || out_valid5 !== 1'b0 || busy5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut5: got ready=%b valid=%b busy=%b expected 1 0 0",
                     in_ready5, out_valid5, busy5);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int acc;
        out_ready3 = 1'b1;
        load3(8'd2, 8'd4, 8'd1, "basic", acc);
        wait_valid3(acc, 4, "basic");
        collect3(8'd1, 8'd2, 8'd4, "basic");
    endtask

    task automatic test_stall();
        int acc;
        out_ready3 = 1'b0;
        load3(8'd5, 8'd5, 8'd0, "stall", acc);
        wait_valid3(acc, 4, "stall");
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (out_valid3 !== 1'b1 || out_data3 !== 8'd0 || out_last3 !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%0d last=%b expected 1 0 0",
                         j, out_valid3, out_data3, out_last3);
            end
            @(negedge clk);
        end
        out_ready3 = 1'b1;
        collect3(8'd0, 8'd5, 8'd5, "stall");
    endtask

    task automatic test_descend();
        logic [7:0] v [5];
        logic [7:0] e [5];
        int         gap [5];
        int         acc = 0;
        int         k = 0;
        v[0] = 8'd3;   v[1] = 8'd9; v[2] = 8'd0; v[3] = 8'd255; v[4] = 8'd7;
        e[0] = 8'd255; e[1] = 8'd9; e[2] = 8'd7; e[3] = 8'd3;   e[4] = 8'd0;
        gap[0] = 1; gap[1] = 0; gap[2] = 2; gap[3] = 0; gap[4] = 1;
        out_ready5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                @(negedge clk);
                in_valid5 = 1'b0;
                in_data5  = 8'hAA;
            end
            @(negedge clk);
            in_valid5 = 1'b1;
            in_data5  = v[i];
            acc = cyc;
        end
        // Keep offering a junk element during SORT; it must be ignored.
        @(negedge clk);
        in_data5 = 8'h11;
        checks++;
        if (in_ready5 !== 1'b0 || busy5 !== 1'b1) begin
            errors++;
            $display("FAIL desc_sort_flags: got ready=%b busy=%b expected 0 1", in_ready5, busy5);
        end
        while (out_valid5 !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        in_valid5 = 1'b0;
        checks++;
        if (out_valid5 !== 1'b1 || (cyc - acc) != 6) begin
            errors++;
            $display("FAIL desc_latency: got valid=%b after %0d cycles expected 1 after 6",
                     out_valid5, cyc - acc);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid5 !== 1'b1 || out_data5 !== e[i] || out_last5 !== (i == 4)) begin
                errors++;
                $display("FAIL desc_out[%0d]: got valid=%b data=%0d last=%b expected 1 %0d %b",
                         i, out_valid5, out_data5, out_last5, e[i], (i == 4));
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready5 !== 1'b1 || out_valid5 !== 1'b0) begin
            errors++;
            $display("FAIL desc_return: got ready=%b valid=%b expected 1 0", in_ready5, out_valid5);
        end
    endtask

    task automatic test_reset_mid_sort();
        int acc;
        out_ready3 = 1'b1;
        load3(8'd9, 8'd3, 8'd6, "rst", acc);
        checks++;
        if (busy3 !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_before: got %b expected 1", busy3);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || busy3 !== 1'b0 || out_data3 !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_sort: got ready=%b valid=%b busy=%b data=%0d expected 1 0 0 0",
                     in_ready3, out_valid3, busy3, out_data3);
        end
        rst_n = 1'b1;
        load3(8'd8, 8'd1, 8'd4, "after_rst", acc);
        wait_valid3(acc, 4, "after_rst");
        collect3(8'd1, 8'd4, 8'd8, "after_rst");
    endtask

    task automatic test_presorted();
        int acc;
        int exp_lat;
`ifdef SORTER_EARLY_EXIT_EN
        exp_lat = 3;
`else
        exp_lat = 4;
`endif
        out_ready3 = 1'b1;
        load3(8'd1, 8'd2, 8'd3, "sorted", acc);
        wait_valid3(acc, exp_lat, "sorted");
        collect3(8'd1, 8'd2, 8'd3, "sorted");
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid3  = 1'b0;
        in_data3   = 8'h00;
        out_ready3 = 1'b0;
        in_valid5  = 1'b0;
        in_data5   = 8'h00;
        out_ready5 = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_descend();
        test_reset_mid_sort();
        test_presorted();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
